// File: rtl/ps2_pkg.sv
// Shared constants, state enums and scancode helpers for the PS/2 direction decoder.
// The typematic build option is selected with the PS2_TYPEMATIC_EN macro.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [2:0] DIR_UP    = 3'b100;
    localparam logic [2:0] DIR_DOWN  = 3'b011;
    localparam logic [2:0] DIR_LEFT  = 3'b001;
    localparam logic [2:0] DIR_RIGHT = 3'b010;
    localparam logic [2:0] DIR_NONE  = 3'b000;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        DEC_NORM,
        DEC_EXT,
        DEC_BRK,
        DEC_EXT_BRK
    } dec_state_t;

    function automatic logic [2:0] dir_of(input logic [7:0] sc);
        case (sc)
            SC_UP:    return DIR_UP;
            SC_DOWN:  return DIR_DOWN;
            SC_LEFT:  return DIR_LEFT;
            SC_RIGHT: return DIR_RIGHT;
            default:  return DIR_NONE;
        endcase
    endfunction

    // One hold bit per direction: [0] up, [1] down, [2] left, [3] right.
    function automatic logic [3:0] dir_mask(input logic [2:0] dir);
        case (dir)
            DIR_UP:    return 4'b0001;
            DIR_DOWN:  return 4'b0010;
            DIR_LEFT:  return 4'b0100;
            DIR_RIGHT: return 4'b1000;
            default:   return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/ps2_dir_decoder_if.sv
// Pin and result bundle of the PS/2 direction decoder.
// The slave side is the decoder; the master side drives the PS/2 pins and observes results.
interface ps2_dir_decoder_if;

    logic       ps2_clk;
    logic       ps2_data;
    logic [2:0] up;
    logic [7:0] scancode;
    logic       code_valid;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data,
        input  up, scancode, code_valid, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output up, scancode, code_valid, frame_err
    );

endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, ps2_clk glitch filter, falling-edge detect,
// 11-bit frame FSM and mid-frame timeout. Byte/error strobes are combinational in the edge cycle.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [1:0]       r_clk_sync;
    logic [1:0]       r_data_sync;
    logic [CNT_W-1:0] r_filt_cnt;
    logic             r_clk_filt;
    logic             r_clk_filt_d;
    logic             w_fall;
    logic             w_data;

    rx_state_t r_state, w_state_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic [2:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic        r_parity, w_parity_nxt;
    logic [15:0] r_tmo_cnt, w_tmo_cnt_nxt;

    // NOTE: reset is synchronous and sampled only inside the clocked block.
    // Pins idle high, so every synchronizer/filter stage resets to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_sync   <= 2'b11;
            r_data_sync  <= 2'b11;
            r_filt_cnt   <= '0;
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
        end else begin
            r_clk_sync   <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync  <= {r_data_sync[0], i_ps2_data};
            r_clk_filt_d <= r_clk_filt;
            if (r_clk_sync[1] == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == CNT_W'(FILTER_LEN - 1)) begin
                r_clk_filt <= r_clk_sync[1];
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    assign w_fall = r_clk_filt_d & ~r_clk_filt;
    assign w_data = r_data_sync[1];
    assign o_byte = r_shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RX_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_parity  <= w_parity_nxt;
            r_tmo_cnt <= w_tmo_cnt_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_parity_nxt  = r_parity;
        o_byte_valid  = 1'b0;
        o_frame_err   = 1'b0;

        if (w_fall) begin
            case (r_state)
                RX_IDLE: begin
                    if (!w_data) begin
                        w_state_nxt   = RX_DATA;
                        w_bit_cnt_nxt = '0;
                    end
                end
                RX_DATA: begin
                    w_shift_nxt   = {w_data, r_shift[7:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == 3'd7) w_state_nxt = RX_PARITY;
                end
                RX_PARITY: begin
                    w_parity_nxt = w_data;
                    w_state_nxt  = RX_STOP;
                end
                RX_STOP: begin
                    w_state_nxt = RX_IDLE;
                    if ((^{r_shift, r_parity}) && w_data) o_byte_valid = 1'b1;
                    else                                  o_frame_err  = 1'b1;
                end
                default: w_state_nxt = RX_IDLE;
            endcase
        end else if (r_state != RX_IDLE && r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            w_state_nxt = RX_IDLE;
            o_frame_err = 1'b1;
        end

        w_tmo_cnt_nxt = (w_fall || w_state_nxt == RX_IDLE) ? 16'd0 : r_tmo_cnt + 16'd1;
    end

endmodule

// File: rtl/ps2_dir_decoder.sv
// PS/2 set-2 arrow/keypad decoder producing one-cycle direction pulses for the VGA sync stage.
// Define PS2_TYPEMATIC_EN to pulse on every make code, including typematic repeats.
module ps2_dir_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               reset,
    ps2_dir_decoder_if.slave   bus
);

    logic [7:0] w_byte;
    logic       w_byte_valid;
    logic       w_frame_err;
    logic [2:0] w_dir;

    dec_state_t r_dec_state, w_dec_state_nxt;
    logic [2:0] r_up, w_up_nxt;
    logic [7:0] r_scancode;
    logic       r_code_valid;
    logic       r_frame_err;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk          (clk),
        .reset        (reset),
        .i_ps2_clk    (bus.ps2_clk),
        .i_ps2_data   (bus.ps2_data),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (w_frame_err)
    );

    assign w_dir = dir_of(w_byte);

`ifndef PS2_TYPEMATIC_EN
    logic [3:0] r_hold, w_hold_nxt;
    logic [3:0] w_mask;
    assign w_mask = dir_mask(w_dir);

    always_ff @(posedge clk) begin
        if (reset) r_hold <= '0;
        else       r_hold <= w_hold_nxt;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dec_state  <= DEC_NORM;
            r_up         <= DIR_NONE;
            r_scancode   <= '0;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_dec_state  <= w_dec_state_nxt;
            r_up         <= w_up_nxt;
            r_code_valid <= w_byte_valid;
            r_frame_err  <= w_frame_err;
            if (w_byte_valid) r_scancode <= w_byte;
        end
    end

    always_comb begin
        w_dec_state_nxt = r_dec_state;
        w_up_nxt        = DIR_NONE;
`ifndef PS2_TYPEMATIC_EN
        w_hold_nxt      = r_hold;
`endif
        if (w_byte_valid) begin
            case (r_dec_state)
                DEC_NORM, DEC_EXT: begin
                    if (w_byte == SC_BRK) begin
                        w_dec_state_nxt = (r_dec_state == DEC_EXT) ? DEC_EXT_BRK : DEC_BRK;
                    end else if (w_byte == SC_EXT && r_dec_state == DEC_NORM) begin
                        w_dec_state_nxt = DEC_EXT;
                    end else begin
                        w_dec_state_nxt = DEC_NORM;
                        if (w_dir != DIR_NONE) begin
`ifdef PS2_TYPEMATIC_EN
                            w_up_nxt = w_dir;
`else
                            // A make for an already-held key is a typematic repeat.
                            if ((r_hold & w_mask) == 4'b0000) w_up_nxt = w_dir;
                            w_hold_nxt = r_hold | w_mask;
`endif
                        end
                    end
                end
                default: begin
`ifndef PS2_TYPEMATIC_EN
                    w_hold_nxt = r_hold & ~w_mask;
`endif
                    w_dec_state_nxt = DEC_NORM;
                end
            endcase
        end
    end

    assign bus.up         = r_up;
    assign bus.scancode   = r_scancode;
    assign bus.code_valid = r_code_valid;
    assign bus.frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Self-checking bench for ps2_dir_decoder: table of PS/2 frames with a scoreboard of
// expected output events, plus timeout and mid-frame reset sequences.
module tb_ps2_dir_decoder;

    localparam int TMO  = 1000;
    localparam int HALF = 20;
    localparam int GAP  = 40;

`ifdef PS2_TYPEMATIC_EN
    localparam logic [2:0] REP_UP = 3'b010;
`else
    localparam logic [2:0] REP_UP = 3'b000;
`endif

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         bad_stop;
        logic [2:0] exp_up;
    } vec_t;

    typedef struct {
        bit         err;
        logic [7:0] sc;
        logic [2:0] up;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0] sc_last = 8'h00;
    ev_t  exp_q[$];

    ps2_dir_decoder_if bus ();

    ps2_dir_decoder #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard: every cycle with any output activity must match the next expected event.
    always @(negedge clk) begin
        if (!reset && (bus.code_valid || bus.frame_err || bus.up != 3'b000)) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL spurious: valid=%0b err=%0b sc=%h up=%b, nothing expected",
                         bus.code_valid, bus.frame_err, bus.scancode, bus.up);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (bus.code_valid !== !e.err || bus.frame_err !== e.err ||
                    bus.scancode !== e.sc || bus.up !== e.up) begin
                    n_err++;
                    $display("FAIL event: got valid=%0b err=%0b sc=%h up=%b, want valid=%0b err=%0b sc=%h up=%b",
                             bus.code_valid, bus.frame_err, bus.scancode, bus.up,
                             !e.err, e.err, e.sc, e.up);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic drive_bit(input logic b);
        bus.ps2_data = b;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic push_exp(input bit err, input logic [7:0] sc, input logic [2:0] up);
        ev_t e;
        e.err = err;
        e.sc  = sc;
        e.up  = up;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] data, input bit bad_par, input bit bad_stop,
                             input logic [2:0] exp_up);
        logic [10:0] bits;
        bits = {~bad_stop, (~^data) ^ bad_par, data, 1'b0};
        if (bad_par || bad_stop) begin
            push_exp(1'b1, sc_last, 3'b000);
        end else begin
            push_exp(1'b0, data, exp_up);
            sc_last = data;
        end
        for (int i = 0; i < 11; i++) drive_bit(bits[i]);
        bus.ps2_data = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    vec_t tbl[32];

    initial begin
        int n;
        tbl = '{
            '{8'hE0, 0, 0, 3'b000}, '{8'h75, 0, 0, 3'b100},
            '{8'hE0, 0, 0, 3'b000}, '{8'hF0, 0, 0, 3'b000}, '{8'h75, 0, 0, 3'b000},
            '{8'h6B, 0, 0, 3'b001}, '{8'h72, 0, 0, 3'b011},
            '{8'hE0, 0, 0, 3'b000}, '{8'hF0, 0, 0, 3'b000}, '{8'h74, 0, 0, 3'b000},
            '{8'hF0, 0, 0, 3'b000}, '{8'h6B, 0, 0, 3'b000},
            '{8'hF0, 0, 0, 3'b000}, '{8'h72, 0, 0, 3'b000},
            '{8'h75, 1, 0, 3'b000}, '{8'h75, 0, 0, 3'b100},
            '{8'h1C, 0, 1, 3'b000},
            '{8'hF0, 0, 0, 3'b000}, '{8'h75, 0, 0, 3'b000},
            '{8'hE0, 0, 0, 3'b000}, '{8'h1C, 0, 0, 3'b000}, '{8'h1C, 0, 0, 3'b000},
            '{8'hE0, 0, 0, 3'b000}, '{8'h6B, 0, 0, 3'b001},
            '{8'hF0, 0, 0, 3'b000}, '{8'h6B, 0, 0, 3'b000},
            '{8'h74, 0, 0, 3'b010}, '{8'h74, 0, 0, REP_UP}, '{8'h74, 0, 0, REP_UP},
            '{8'hF0, 0, 0, 3'b000}, '{8'h74, 0, 0, 3'b000}, '{8'h74, 0, 0, 3'b010}
        };

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_outputs", {20'd0, bus.up, bus.scancode, bus.code_valid, bus.frame_err}, 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        foreach (tbl[i]) send_byte(tbl[i].data, tbl[i].bad_par, tbl[i].bad_stop, tbl[i].exp_up);

        // Start bit plus five data bits, then the clock stops.
        push_exp(1'b1, sc_last, 3'b000);
        drive_bit(1'b0);
        for (int i = 0; i < 5; i++) drive_bit(1'b1);
        n = HALF;
        while (!bus.frame_err && n < TMO + 200) begin
            @(negedge clk);
            n++;
        end
        check("timeout_seen", {31'd0, bus.frame_err}, 32'd1);
        check("timeout_window", {31'd0, (n >= TMO + 5 && n <= TMO + 30)}, 32'd1);
        repeat (GAP) @(negedge clk);
        send_byte(8'h72, 0, 0, 3'b011);

        // Reset in the middle of a frame: partial frame dropped silently.
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        reset = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        sc_last = 8'h00;
        check("scancode_after_reset", {24'd0, bus.scancode}, 32'd0);
        repeat (GAP) @(negedge clk);
        send_byte(8'h6B, 0, 0, 3'b001);

        repeat (200) @(negedge clk);
        check("events_outstanding", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
